// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT stage sequencer slice.
//   FFT_N_DEFAULT : default log2 of the transform size
//   STAGE_W       : width of the stage counter driven to the address generator
//   fft_state_t   : sequencer state encoding (also exported on the debug port)
// -----------------------------------------------------------------------------
package fft_pkg;

   localparam int FFT_N_DEFAULT = 10;
   localparam int STAGE_W       = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DONE  = 3'd4
   } fft_state_t;

endpackage

// File: rtl/fft_delay_line.sv
// -----------------------------------------------------------------------------
// fft_delay_line
// Fixed-depth shift register: dout equals din from DEPTH cycles earlier.
// Shifts every cycle. rst_n clears it asynchronously; clr flushes every
// stage to zero on the next clock edge instead of shifting.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   clr   : synchronous flush
//   din   : WIDTH-bit input
//   dout  : WIDTH-bit output, delayed DEPTH cycles
// -----------------------------------------------------------------------------
module fft_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_q [DEPTH];
   logic [WIDTH-1:0] pipe_d [DEPTH];

   always_comb begin
      pipe_d[0] = clr ? '0 : din;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = clr ? '0 : pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
// Steps an in-place radix-2 FFT through FFT_N stages. For each stage it asks
// the address generator to run, waits for gen_done, lets the butterfly
// pipeline drain for DRAIN_LAT cycles, then advances the stage and swaps the
// ping-pong banks. Write address/enable are the generator's read address and
// valid flag delayed by the butterfly latency.
//
// Handshake: should_run is a level request held for the whole RUN state; the
// generator streams addresses (gen_active) while it is high and raises
// gen_done once the stage's last address has been issued. The first cycle
// gen_done is seen in RUN ends the request; should_run drops next cycle.
//
// Parameters: FFT_N (log2 points), DRAIN_LAT (2..15 pipeline latency).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : transform request, honoured only in IDLE
//   abort               : (only with FFT_SEQ_ABORT_EN) return to IDLE at once
//   ready               : high in IDLE
//   stage_count         : current stage to the address generator
//   should_run          : run request to the address generator
//   gen_done/gen_active : generator stage-complete / address-valid flags
//   rd_addr             : butterfly read address from the generator
//   wr_addr/wr_en       : rd_addr/gen_active delayed by DRAIN_LAT
//   rd_bank             : ping-pong bank being read (write bank is ~rd_bank)
//   stage_done          : one-cycle pulse after each stage drains
//   fft_done            : one-cycle pulse after the final stage drains
//   state_dbg           : current FSM state
// Optional feature macro: FFT_SEQ_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int FFT_N     = FFT_N_DEFAULT,
   parameter int DRAIN_LAT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
`ifdef FFT_SEQ_ABORT_EN
   input  logic               abort,
`endif
   output logic               ready,
   output logic [STAGE_W-1:0] stage_count,
   output logic               should_run,
   input  logic               gen_done,
   input  logic               gen_active,
   input  logic [FFT_N-2:0]   rd_addr,
   output logic [FFT_N-2:0]   wr_addr,
   output logic               wr_en,
   output logic               rd_bank,
   output logic               stage_done,
   output logic               fft_done,
   output fft_state_t         state_dbg
);

   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(FFT_N - 1);
   localparam logic [3:0]         DRAIN_INIT = 4'(DRAIN_LAT - 1);

   fft_state_t         state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic               bank_q, bank_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               run_q, run_d;
   logic               sdone_q, sdone_d;
   logic               fdone_q, fdone_d;
   logic               abort_go;
   logic [FFT_N-1:0]   dly_out;

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      bank_d   = bank_q;
      cnt_d    = cnt_q;
      abort_go = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               stage_d = '0;
               bank_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (gen_done) begin
               state_d = ST_DRAIN;
               cnt_d   = DRAIN_INIT;
            end
         end
         // Counter runs DRAIN_LAT-1 .. 0, so DRAIN occupies DRAIN_LAT cycles.
         ST_DRAIN: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_NEXT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_NEXT: begin
            if (stage_q == LAST_STAGE) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
               stage_d = stage_q + STAGE_W'(1);
               bank_d  = ~bank_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef FFT_SEQ_ABORT_EN
      // Abort overrides every transition; stage and bank are left as they were.
      if (abort && (state_q != ST_IDLE)) begin
         abort_go = 1'b1;
         state_d  = ST_IDLE;
         stage_d  = stage_q;
         bank_d   = bank_q;
      end
`endif

      // Outputs are registered as a decode of the next state, so each one
      // equals a decode of the registered state during the following cycle.
      ready_d = (state_d == ST_IDLE);
      run_d   = (state_d == ST_RUN);
      sdone_d = (state_d == ST_NEXT);
      fdone_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         bank_q  <= 1'b0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         run_q   <= 1'b0;
         sdone_q <= 1'b0;
         fdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         bank_q  <= bank_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         run_q   <= run_d;
         sdone_q <= sdone_d;
         fdone_q <= fdone_d;
      end
   end

   // Valid flag rides in the top bit alongside the address.
   fft_delay_line #(
      .WIDTH (FFT_N),
      .DEPTH (DRAIN_LAT)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort_go),
      .din   ({gen_active, rd_addr}),
      .dout  (dly_out)
   );

   assign wr_en       = dly_out[FFT_N-1];
   assign wr_addr     = dly_out[FFT_N-2:0];
   assign ready       = ready_q;
   assign should_run  = run_q;
   assign stage_count = stage_q;
   assign rd_bank     = bank_q;
   assign stage_done  = sdone_q;
   assign fft_done    = fdone_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;
   import fft_pkg::*;

   localparam int N  = 4;
   localparam int DL = 3;
   localparam int AW = N - 1;
   localparam int BF = 1 << (N - 1);   // butterflies per stage

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
`ifdef FFT_SEQ_ABORT_EN
   logic abort = 1'b0;
`endif
   logic          ready, should_run, gen_done, gen_active;
   logic          wr_en, rd_bank, stage_done, fft_done;
   logic [4:0]    stage_count;
   logic [AW-1:0] rd_addr, wr_addr;
   fft_state_t    state_dbg;

   always #5 clk = ~clk;

   fft_stage_sequencer #(.FFT_N(N), .DRAIN_LAT(DL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
`ifdef FFT_SEQ_ABORT_EN
      .abort       (abort),
`endif
      .ready       (ready),
      .stage_count (stage_count),
      .should_run  (should_run),
      .gen_done    (gen_done),
      .gen_active  (gen_active),
      .rd_addr     (rd_addr),
      .wr_addr     (wr_addr),
      .wr_en       (wr_en),
      .rd_bank     (rd_bank),
      .stage_done  (stage_done),
      .fft_done    (fft_done),
      .state_dbg   (state_dbg)
   );

   // ---------------- address generator model ----------------
   // While should_run is high: one idle cycle, BF active addresses 0..BF-1,
   // then gen_done. Outputs are gated by should_run.
   logic [AW-1:0] g_addr = '0;
   logic          g_act  = 1'b0;
   logic          g_done = 1'b0;

   always @(posedge clk) begin
      if (!should_run) begin
         g_act  <= 1'b0;
         g_done <= 1'b0;
         g_addr <= '0;
      end else if (!g_act && !g_done) begin
         g_act <= 1'b1;
      end else if (g_act) begin
         if (g_addr == AW'(BF - 1)) begin
            g_act  <= 1'b0;
            g_done <= 1'b1;
         end else begin
            g_addr <= g_addr + 1'b1;
         end
      end
   end

   assign gen_active = g_act & should_run;
   assign gen_done   = g_done & should_run;
   assign rd_addr    = g_addr;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   int cnt_sd = 0, cnt_fd = 0, cnt_wr = 0, sd_idx = 0, wr_base = 0;
   logic [AW-1:0] exp_q[$];   // rd_addr history, oldest first

   int exp_stage_t [4] = '{0, 1, 2, 3};
   int exp_bank_t  [4] = '{0, 1, 0, 1};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() == DL) begin
         if (wr_en) begin
            cnt_wr++;
            check("wr_addr_delay", int'(wr_addr), int'(exp_q[0]));
         end
         void'(exp_q.pop_front());
      end else if (wr_en) begin
         cnt_wr++;
      end
      exp_q.push_back(rd_addr);
      if (stage_done) begin
         if (sd_idx < 4) begin
            check("sd_stage_count", int'(stage_count), exp_stage_t[sd_idx]);
            check("sd_rd_bank", int'(rd_bank), exp_bank_t[sd_idx]);
            check("sd_wr_before", cnt_wr - wr_base, BF * (sd_idx + 1));
         end else begin
            check("sd_extra_pulse", sd_idx, 3);
         end
         sd_idx++;
         cnt_sd++;
      end
      if (fft_done) begin
         cnt_fd++;
         check("fd_after_4_stages", sd_idx, 4);
         sd_idx  = 0;
         wr_base = cnt_wr;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_counts();
      cnt_sd = 0; cnt_fd = 0; cnt_wr = 0; sd_idx = 0; wr_base = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_fft_done(input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (fft_done) got = 1'b1;
      end
      check("fft_done_within_budget", int'(got), 1);
   endtask

   task automatic wait_stage_state(input int stg, input fft_state_t st, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (int'(stage_count) == stg && state_dbg == st) got = 1'b1;
      end
      check("reach_stage_state", int'(got), 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit stray_start;
      int exp_sd;
      int exp_fd;
      int exp_wr;
      int exp_stage_end;
      int exp_bank_end;
   } vec_t;

   vec_t vecs [2];

   initial begin
      vecs[0] = '{stray_start: 1'b0, exp_sd: 4, exp_fd: 1, exp_wr: 32, exp_stage_end: 3, exp_bank_end: 1};
      vecs[1] = '{stray_start: 1'b1, exp_sd: 4, exp_fd: 1, exp_wr: 32, exp_stage_end: 3, exp_bank_end: 1};

      // reset values
      #12;
      check("rst_ready", int'(ready), 1);
      check("rst_should_run", int'(should_run), 0);
      check("rst_stage_count", int'(stage_count), 0);
      check("rst_rd_bank", int'(rd_bank), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_stage_done", int'(stage_done), 0);
      check("rst_fft_done", int'(fft_done), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven single transforms
      for (int v = 0; v < 2; v++) begin
         clear_counts();
         pulse_start();
         check("run_after_start", int'(should_run), 1);
         check("ready_low_in_run", int'(ready), 0);
         check("start_stage0", int'(stage_count), 0);
         check("start_bank0", int'(rd_bank), 0);
         if (vecs[v].stray_start) begin
            repeat (2) @(negedge clk);
            pulse_start();
            check("stray_start_stage", int'(stage_count), 0);
            wait_stage_state(2, ST_RUN, 100);
            pulse_start();
            check("stray_start_stage2", int'(stage_count), 2);
         end
         wait_fft_done(200);
         repeat (12) @(negedge clk);
         #1;
         check("vec_stage_done_cnt", cnt_sd, vecs[v].exp_sd);
         check("vec_fft_done_cnt", cnt_fd, vecs[v].exp_fd);
         check("vec_wr_en_cnt", cnt_wr, vecs[v].exp_wr);
         check("vec_ready_end", int'(ready), 1);
         check("vec_stage_hold", int'(stage_count), vecs[v].exp_stage_end);
         check("vec_bank_hold", int'(rd_bank), vecs[v].exp_bank_end);
      end

      // start held high: back-to-back transforms with an IDLE gap
      clear_counts();
      @(negedge clk); start = 1'b1;
      wait_fft_done(200);
      @(negedge clk);
      check("b2b_idle_ready", int'(ready), 1);
      check("b2b_idle_no_run", int'(should_run), 0);
      @(negedge clk);
      check("b2b_restart_run", int'(should_run), 1);
      check("b2b_restart_stage", int'(stage_count), 0);
      check("b2b_restart_bank", int'(rd_bank), 0);
      wait_fft_done(200);
      start = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      check("b2b_fft_done_cnt", cnt_fd, 2);
      check("b2b_stage_done_cnt", cnt_sd, 8);
      check("b2b_wr_en_cnt", cnt_wr, 64);

      // asynchronous reset during stage 2 drain
      clear_counts();
      pulse_start();
      wait_stage_state(2, ST_DRAIN, 200);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", int'(ready), 1);
      check("arst_stage_count", int'(stage_count), 0);
      check("arst_should_run", int'(should_run), 0);
      check("arst_rd_bank", int'(rd_bank), 0);
      check("arst_wr_en", int'(wr_en), 0);
      check("arst_wr_addr", int'(wr_addr), 0);
      check("arst_stage_done", int'(stage_done), 0);
      check("arst_fft_done", int'(fft_done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("arst_no_fft_done", cnt_fd, 0);
      check("arst_stays_idle", int'(ready), 1);
      clear_counts();
      pulse_start();
      check("arst_restart_stage", int'(stage_count), 0);
      wait_fft_done(200);
      repeat (12) @(negedge clk);
      #1;
      check("arst_rerun_sd_cnt", cnt_sd, 4);
      check("arst_rerun_fd_cnt", cnt_fd, 1);
      check("arst_rerun_wr_cnt", cnt_wr, 32);

`ifdef FFT_SEQ_ABORT_EN
      // abort in stage 1 RUN with writes in flight
      clear_counts();
      pulse_start();
      begin
         bit got = 1'b0;
         for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (int'(stage_count) == 1 && gen_active) got = 1'b1;
         end
         check("abort_reach_stage1", int'(got), 1);
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_ready", int'(ready), 1);
      check("abort_no_run", int'(should_run), 0);
      check("abort_wr_en", int'(wr_en), 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_wr_en_hold", int'(wr_en), 0);
      end
      #1;
      check("abort_sd_cnt", cnt_sd, 1);
      check("abort_fd_cnt", cnt_fd, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
